// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller beside the ID/EX register: tracks dst info for EX/MEM/WB,
// raises load-use stall and branch flush, and registers forward selects for the next EX cycle.
module hazard_fwd_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_src0,
  input  logic [3:0]  id_src1,
  input  logic        id_use_src0,
  input  logic        id_use_src1,
  input  logic [3:0]  id_dst,
  input  logic        id_we,
  input  logic        id_load,
  input  logic        br_ctrl,
  output logic        stall,
  output logic        flush,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef struct packed {
    logic [3:0] dst;
    logic       we;
    logic       load;
  } shadow_t;

  shadow_t    ex_reg, mem_reg, wb_reg, ex_next;
  logic       ex_eff, mem_eff, hazard, issue;
  logic [1:0] fwd_a_next, fwd_b_next;

  // A write to R0 is discarded, so it can never be a producer.
  assign ex_eff  = ex_reg.we  & (ex_reg.dst  != 4'd0);
  assign mem_eff = mem_reg.we & (mem_reg.dst != 4'd0);

  assign hazard = id_valid & ex_eff & ex_reg.load &
                  ((id_use_src0 & (ex_reg.dst == id_src0)) |
                   (id_use_src1 & (ex_reg.dst == id_src1)));

  assign flush = br_ctrl & ~rst;
  assign stall = hazard & ~br_ctrl & ~rst;
  assign issue = id_valid & ~stall & ~flush;

  function automatic logic [1:0] fwd_sel(input logic rd, input logic [3:0] src,
                                         input shadow_t ex_s, input logic ex_w,
                                         input shadow_t mem_s, input logic mem_w);
    if (rd && ex_w && !ex_s.load && ex_s.dst == src)
      return 2'b10;
    else if (rd && mem_w && mem_s.dst == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    ex_next    = '0;
    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if (issue) begin
      ex_next    = '{dst: id_dst, we: id_we, load: id_load};
      fwd_a_next = fwd_sel(id_use_src0, id_src0, ex_reg, ex_eff, mem_reg, mem_eff);
      fwd_b_next = fwd_sel(id_use_src1, id_src1, ex_reg, ex_eff, mem_reg, mem_eff);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_reg      <= '0;
      mem_reg     <= '0;
      wb_reg      <= '0;
      forwardA    <= 2'b00;
      forwardB    <= 2'b00;
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      wb_reg   <= mem_reg;
      mem_reg  <= ex_reg;
      ex_reg   <= ex_next;
      forwardA <= fwd_a_next;
      forwardB <= fwd_b_next;
      if (stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if (flush && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end

  // WB and the MEM load flag are tracked for pipeline visibility but feed no decision.
  logic unused_shadow;
  assign unused_shadow = ^{wb_reg, mem_reg.load};

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed scenarios plus randomized traffic against a model
// that remembers the last issued instructions by age.
module tb_hazard_fwd_ctrl;

  logic        clk, rst;
  logic        id_valid, id_use_src0, id_use_src1, id_we, id_load, br_ctrl;
  logic [3:0]  id_src0, id_src1, id_dst;
  logic        stall, flush;
  logic [1:0]  forwardA, forwardB;
  logic [15:0] stall_count, flush_count;

  hazard_fwd_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src0(id_src0), .id_src1(id_src1),
    .id_use_src0(id_use_src0), .id_use_src1(id_use_src1), .id_dst(id_dst), .id_we(id_we),
    .id_load(id_load), .br_ctrl(br_ctrl), .stall(stall), .flush(flush),
    .forwardA(forwardA), .forwardB(forwardB), .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: age[k] is the instruction that entered EX k+1 cycles ago (bubble = no write).
  typedef struct {
    int dst;
    bit wr;
    bit ld;
  } slot_t;
  slot_t age[3];
  bit exp_stall, exp_flush;
  int exp_fa, exp_fb, nxt_fa, nxt_fb;
  int exp_sc, exp_fc;
  bit obs_stall, obs_flush;

  function automatic int producer_sel(bit rd, int src);
    // Youngest ALU producer can bypass from MEM; one older producer bypasses from WB.
    if (!rd || src == 0) return 0;
    if (age[0].wr && age[0].dst == src && !age[0].ld) return 2;
    if (age[0].wr && age[0].dst == src) return 0;
    if (age[1].wr && age[1].dst == src) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) age[k] = '{0, 0, 0};
    exp_fa = 0; exp_fb = 0; exp_sc = 0; exp_fc = 0;
  endtask

  task automatic model_eval();
    bit dep, issued;
    dep = age[0].wr && age[0].ld && age[0].dst != 0 &&
          ((id_use_src0 && int'(id_src0) == age[0].dst) || (id_use_src1 && int'(id_src1) == age[0].dst));
    exp_flush = br_ctrl;
    exp_stall = id_valid && dep && !br_ctrl;
    issued = id_valid && !exp_stall && !exp_flush;
    nxt_fa = issued ? producer_sel(id_use_src0, int'(id_src0)) : 0;
    nxt_fb = issued ? producer_sel(id_use_src1, int'(id_src1)) : 0;
    age[2] = age[1];
    age[1] = age[0];
    age[0] = issued ? '{int'(id_dst), id_we && id_dst != 0, id_load} : '{0, 0, 0};
  endtask

  task automatic model_commit();
    exp_fa = nxt_fa;
    exp_fb = nxt_fb;
    if (exp_stall && exp_sc < 65535) exp_sc++;
    if (exp_flush && exp_fc < 65535) exp_fc++;
  endtask

  task automatic set_in(bit v, int s0, bit u0, int s1, bit u1, int d, bit we, bit ld, bit br);
    id_valid = v; id_src0 = 4'(s0); id_use_src0 = u0; id_src1 = 4'(s1); id_use_src1 = u1;
    id_dst = 4'(d); id_we = we; id_load = ld; br_ctrl = br;
  endtask

  // One ID slot: drive at negedge, sample comb outputs, then advance past the posedge.
  task automatic drive(bit v, int s0, bit u0, int s1, bit u1, int d, bit we, bit ld, bit br);
    @(negedge clk);
    set_in(v, s0, u0, s1, u1, d, we, ld, br);
    #1;
    obs_stall = stall;
    obs_flush = flush;
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({stall, flush, forwardA, forwardB, stall_count, flush_count} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_state: got stall=%b flush=%b fA=%b fB=%b sc=%0d fc=%0d, want all 0",
               stall, flush, forwardA, forwardB, stall_count, flush_count);
    end
    do_reset();
  endtask

  task automatic test_fwd_ex();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);       // ADD R1
    drive(1, 1, 1, 4, 1, 2, 1, 0, 0);       // ADD R2,R1,R4
    n_checks++;
    if (obs_stall !== 1'b0 || forwardA !== 2'b10 || forwardB !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_ex: got stall=%b fA=%b fB=%b, want 0 10 00", obs_stall, forwardA, forwardB);
    end
  endtask

  task automatic test_fwd_mem();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);       // ADD R1
    nop();
    drive(1, 6, 1, 1, 1, 5, 1, 0, 0);       // SUB R5,R6,R1
    n_checks++;
    if (forwardA !== 2'b00 || forwardB !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_mem: got fA=%b fB=%b, want 00 01", forwardA, forwardB);
    end
  endtask

  task automatic test_newest_wins();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 1, 1, 1, 1, 7, 1, 0, 0);       // AND R7,R1,R1
    n_checks++;
    if (forwardA !== 2'b10 || forwardB !== 2'b10) begin
      n_fail++;
      $display("FAIL newest_wins: got fA=%b fB=%b, want 10 10", forwardA, forwardB);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0);       // LW R3
    n_checks++;
    if (obs_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_no_early_stall: got stall=%b, want 0", obs_stall);
    end
    drive(1, 3, 1, 2, 1, 8, 1, 0, 0);       // ADD R8,R3,R2 (stalls)
    n_checks++;
    if (obs_stall !== 1'b1 || forwardA !== 2'b00 || forwardB !== 2'b00 || stall_count !== 16'd1) begin
      n_fail++;
      $display("FAIL lu_stall: got stall=%b fA=%b fB=%b sc=%0d, want 1 00 00 1",
               obs_stall, forwardA, forwardB, stall_count);
    end
    drive(1, 3, 1, 2, 1, 8, 1, 0, 0);       // same ADD re-evaluated
    n_checks++;
    if (obs_stall !== 1'b0 || forwardA !== 2'b01 || forwardB !== 2'b00 || stall_count !== 16'd1) begin
      n_fail++;
      $display("FAIL lu_resume: got stall=%b fA=%b fB=%b sc=%0d, want 0 01 00 1",
               obs_stall, forwardA, forwardB, stall_count);
    end
  endtask

  task automatic test_flush_over_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0);       // LW R3
    drive(1, 3, 1, 2, 1, 8, 1, 0, 1);       // dependent, with branch taken
    n_checks++;
    if (obs_flush !== 1'b1 || obs_stall !== 1'b0 || flush_count !== 16'd1 || stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL flush_over_stall: got flush=%b stall=%b fc=%0d sc=%0d, want 1 0 1 0",
               obs_flush, obs_stall, flush_count, stall_count);
    end
    drive(1, 0, 0, 0, 0, 9, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 9, 1, 0, 1);
    n_checks++;
    if (obs_flush !== 1'b1 || obs_stall !== 1'b0 || flush_count !== 16'd3) begin
      n_fail++;
      $display("FAIL flush_held: got flush=%b stall=%b fc=%0d, want 1 0 3", obs_flush, obs_stall, flush_count);
    end
  endtask

  task automatic test_r0();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);       // load to R0
    drive(1, 0, 1, 0, 1, 5, 1, 0, 0);
    n_checks++;
    if (obs_stall !== 1'b0 || forwardA !== 2'b00 || forwardB !== 2'b00) begin
      n_fail++;
      $display("FAIL r0_load: got stall=%b fA=%b fB=%b, want 0 00 00", obs_stall, forwardA, forwardB);
    end
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);       // ALU to R0
    drive(1, 0, 1, 0, 1, 6, 1, 0, 0);
    n_checks++;
    if (forwardA !== 2'b00 || forwardB !== 2'b00) begin
      n_fail++;
      $display("FAIL r0_alu: got fA=%b fB=%b, want 00 00", forwardA, forwardB);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);       // one flush event
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);       // ADD R5
    drive(1, 5, 1, 0, 0, 3, 1, 1, 0);       // LW R3 using R5 -> fA=10
    @(negedge clk);
    set_in(1, 3, 1, 2, 1, 8, 1, 0, 0);
    #1;
    n_checks++;
    if (stall !== 1'b1 || forwardA !== 2'b10 || flush_count !== 16'd1) begin
      n_fail++;
      $display("FAIL pre_reset: got stall=%b fA=%b fc=%0d, want 1 10 1", stall, forwardA, flush_count);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({stall, flush, forwardA, forwardB, stall_count, flush_count} !== 38'd0) begin
      n_fail++;
      $display("FAIL async_reset: got stall=%b flush=%b fA=%b fB=%b sc=%0d fc=%0d, want all 0",
               stall, flush, forwardA, forwardB, stall_count, flush_count);
    end
    model_reset();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int s0, s1, d;
    bit v, u0, u1, we, ld, br;
    do_reset();
    v = 0; s0 = 0; s1 = 0; u0 = 0; u1 = 0; d = 0; we = 0; ld = 0;
    for (int i = 0; i < 400; i++) begin
      if (!exp_stall || i == 0) begin
        v  = ($urandom_range(0, 5) != 0);
        s0 = $urandom_range(0, 3);  s1 = $urandom_range(0, 3);
        u0 = $urandom_range(0, 1);  u1 = $urandom_range(0, 1);
        d  = $urandom_range(0, 3);  we = ($urandom_range(0, 3) != 0);
        ld = ($urandom_range(0, 2) == 0);
      end
      br = ($urandom_range(0, 7) == 0);
      drive(v, s0, u0, s1, u1, d, we, ld, br);
      n_checks++;
      if (obs_stall !== exp_stall || obs_flush !== exp_flush) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: got stall=%b flush=%b, want %b %b", i, obs_stall, obs_flush, exp_stall, exp_flush);
      end
      n_checks++;
      if (forwardA !== 2'(exp_fa) || forwardB !== 2'(exp_fb)) begin
        n_fail++;
        $display("FAIL rand_fwd[%0d]: got fA=%b fB=%b, want %0d %0d", i, forwardA, forwardB, exp_fa, exp_fb);
      end
      n_checks++;
      if (stall_count !== 16'(exp_sc) || flush_count !== 16'(exp_fc)) begin
        n_fail++;
        $display("FAIL rand_cnt[%0d]: got sc=%0d fc=%0d, want %0d %0d", i, stall_count, flush_count, exp_sc, exp_fc);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_newest_wins();
    test_load_use();
    test_flush_over_stall();
    test_r0();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
